bus_arbiter: RTL and testbench

Parametrised, registered successor to the datapath's combinational bus multiplexer. It drives the shared datapath bus from up to NSRC register/memory sources: PC, IR, AR, AC, X/Y/Z, the ST pairs, R..R3, DM and IM. Sources request the bus explicitly and receive a one-hot grant. The block supports fixed-priority or round-robin arbitration, locked multi-beat bursts with a burst cap, and valid/ready backpressure toward the bus consumer.

---
 rtl/bus_pkg.sv | 32 +++
 rtl/bus_arb_pick.sv | 41 ++++
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the datapath bus arbiter
package bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } bus_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Standard datapath source slots; lower index means higher fixed priority.
    localparam int SRC_PC  = 0;
    localparam int SRC_IR  = 1;
    localparam int SRC_AR  = 2;
    localparam int SRC_AC  = 3;
    localparam int SRC_X   = 4;
    localparam int SRC_Y   = 5;
    localparam int SRC_Z   = 6;
    localparam int SRC_STL = 7;
    localparam int SRC_STH = 8;
    localparam int SRC_R   = 9;
    localparam int SRC_R1  = 10;
    localparam int SRC_R2  = 11;
    localparam int SRC_R3  = 12;
    localparam int SRC_DM  = 13;
    localparam int SRC_IM  = 14;
    localparam int SRC_AUX = 15;

    localparam int BURST_W = 8;

endpackage

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - combinational winner select, fixed priority or round-robin
module bus_arb_pick
    import bus_pkg::*;
#(
    parameter int NSRC = 16
) (
    input  logic [NSRC-1:0]         req,
    input  logic [$clog2(NSRC)-1:0] rr_ptr,
    input  logic                    mode,
    output logic [NSRC-1:0]         win_onehot,
    output logic [$clog2(NSRC)-1:0] win_id
);

    localparam int IDW = $clog2(NSRC);

    int             idx_i;
    logic [IDW-1:0] idx;
    logic           found;

    // Round-robin scans from the slot just after rr_ptr, wrapping modulo NSRC.
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx_i  = 0;
        idx    = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (mode == ARB_RR) begin
                idx_i = (int'(rr_ptr) + 1 + k) % NSRC;
            end else begin
                idx_i = k;
            end
            idx = IDW'(idx_i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        win_onehot = found ? (NSRC'(1) << win_id) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - registered datapath bus arbiter with locked bursts and backpressure
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NSRC      = 16,
    parameter int WIDTH     = 24,
    parameter int RR_MODE   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read_en,
    input  logic [NSRC-1:0]         req,
    input  logic [NSRC-1:0]         lock,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic                    sink_ready,
    output logic [WIDTH-1:0]        busout,
    output logic                    bus_valid,
    output logic [NSRC-1:0]         grant,
    output logic [$clog2(NSRC)-1:0] grant_id,
    output logic [BURST_W-1:0]      burst_cnt
);

    localparam int                 IDW        = $clog2(NSRC);
    localparam logic               MODE       = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    bus_state_e         state_q, state_d;
    logic [WIDTH-1:0]   busout_q, busout_d;
    logic [NSRC-1:0]    grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [WIDTH-1:0]   src_arr [NSRC];
    logic [NSRC-1:0]    pick_onehot;
    logic [IDW-1:0]     pick_id;
    logic               load_opp;
    logic               cont;
    logic               arb;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
    end

    bus_arb_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .mode       (MODE),
        .win_onehot (pick_onehot),
        .win_id     (pick_id)
    );

    // A stalled beat (valid without ready) never reaches a load opportunity.
    assign load_opp = (state_q == ST_IDLE) || sink_ready;
    assign cont     = (state_q == ST_XFER) && read_en && lock[grant_id_q]
                      && req[grant_id_q] && (burst_cnt_q < BURST_LAST);
    assign arb      = !cont && read_en && (|req);

    always_comb begin
        state_d     = state_q;
        busout_d    = busout_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (load_opp) begin
            if (cont) begin
                busout_d    = src_arr[grant_id_q];
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end else if (arb) begin
                state_d     = ST_XFER;
                busout_d    = src_arr[pick_id];
                grant_d     = pick_onehot;
                grant_id_d  = pick_id;
                rr_ptr_d    = pick_id;
                burst_cnt_d = '0;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busout_q    <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= IDW'(NSRC - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busout_q    <= busout_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign busout    = busout_q;
    assign bus_valid = (state_q == ST_XFER);
    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench, round-robin and fixed-priority instances side by side
module tb_bus_arbiter;

    localparam int NSRC  = 16;
    localparam int WIDTH = 24;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  read_en;
    logic [NSRC-1:0]       req;
    logic [NSRC-1:0]       lock;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  sink_ready;
    logic [WIDTH-1:0]      src_val [NSRC];

    logic [WIDTH-1:0] busout_r, busout_f;
    logic             valid_r, valid_f;
    logic [NSRC-1:0]  grant_r, grant_f;
    logic [3:0]       gid_r, gid_f;
    logic [7:0]       cnt_r, cnt_f;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NSRC; g++) begin : g_flat
        assign src_data[g*WIDTH +: WIDTH] = src_val[g];
    end

    bus_arbiter #(.NSRC(NSRC), .WIDTH(WIDTH), .RR_MODE(1), .MAX_BURST(4)) dut_rr (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .req(req), .lock(lock),
        .src_data(src_data), .sink_ready(sink_ready), .busout(busout_r),
        .bus_valid(valid_r), .grant(grant_r), .grant_id(gid_r), .burst_cnt(cnt_r)
    );

    bus_arbiter #(.NSRC(NSRC), .WIDTH(WIDTH), .RR_MODE(0), .MAX_BURST(4)) dut_fx (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .req(req), .lock(lock),
        .src_data(src_data), .sink_ready(sink_ready), .busout(busout_f),
        .bus_valid(valid_f), .grant(grant_f), .grant_id(gid_f), .burst_cnt(cnt_f)
    );

    typedef struct {
        bit          fx;
        bit          full;
        logic        valid;
        int          gid;
        logic [23:0] data;
        int          cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit fx, input bit full, input logic v, input int gid,
                        input logic [23:0] d, input int cnt, input string tag);
        exp_t e;
        e.fx = fx; e.full = full; e.valid = v; e.gid = gid;
        e.data = d; e.cnt = cnt; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_beat(input int rgid, input int rcnt, input int fgid, input int fcnt,
                            input string tag);
        push(1'b0, 1'b0, 1'b1, rgid, src_val[rgid], rcnt, {tag, ".rr"});
        push(1'b1, 1'b0, 1'b1, fgid, src_val[fgid], fcnt, {tag, ".fx"});
    endtask

    task automatic exp_idle(input logic [23:0] rdata, input logic [23:0] fdata, input string tag);
        push(1'b0, 1'b0, 1'b0, 0, rdata, 0, {tag, ".rr"});
        push(1'b1, 1'b0, 1'b0, 0, fdata, 0, {tag, ".fx"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t        e;
            logic        v;
            logic [23:0] d;
            logic [15:0] gr;
            logic [3:0]  id;
            logic [7:0]  c;
            e = sb.pop_front();
            v  = e.fx ? valid_f  : valid_r;
            d  = e.fx ? busout_f : busout_r;
            gr = e.fx ? grant_f  : grant_r;
            id = e.fx ? gid_f    : gid_r;
            c  = e.fx ? cnt_f    : cnt_r;
            chk({e.tag, ".valid"}, 32'(v), 32'(e.valid));
            chk({e.tag, ".busout"}, 32'(d), 32'(e.data));
            chk({e.tag, ".grant"}, 32'(gr), e.valid ? (32'(1) << e.gid) : 32'(0));
            if (e.valid || e.full) begin
                chk({e.tag, ".grant_id"}, 32'(id), 32'(e.gid));
                chk({e.tag, ".burst_cnt"}, 32'(c), 32'(e.cnt));
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; req = '1; lock = '0; read_en = 1'b1; sink_ready = 1'b1;
        push(1'b0, 1'b1, 1'b0, 0, 24'h0, 0, {tag, ".rr"});
        push(1'b1, 1'b1, 1'b0, 0, 24'h0, 0, {tag, ".fx"});
        tick();
        rst_n = 1'b1; req = '0;
    endtask

    initial begin
        int          rr_seq [3];
        logic [23:0] held;

        for (int i = 0; i < NSRC; i++) src_val[i] = 24'(32'hC00000 + i * 32'h1111);
        rst_n = 1'b0; read_en = 1'b1; req = '0; lock = '0; sink_ready = 1'b1;

        do_reset("reset");
        req = 16'h0005;
        exp_beat(0, 0, 0, 0, "first_grant");
        tick();
        exp_beat(2, 0, 0, 0, "second_grant");
        tick();
        req = 16'h0000;
        exp_idle(src_val[2], src_val[0], "drop_all_req");
        tick();

        do_reset("reset_fixed");
        req = 16'h8003;
        rr_seq[0] = 0; rr_seq[1] = 1; rr_seq[2] = 15;
        for (int k = 0; k < 6; k++) begin
            src_val[0] = 24'h0F0000 + 24'(k);
            exp_beat(rr_seq[k % 3], 0, 0, 0, $sformatf("prio8003_%0d", k));
            tick();
        end

        do_reset("reset_rr");
        req = 16'h0111;
        rr_seq[0] = 0; rr_seq[1] = 4; rr_seq[2] = 8;
        for (int k = 0; k < 6; k++) begin
            exp_beat(rr_seq[k % 3], 0, 0, 0, $sformatf("rr0111_%0d", k));
            tick();
        end

        do_reset("reset_bp");
        req = 16'h0008; src_val[3] = 24'hABCDEF; sink_ready = 1'b0;
        exp_beat(3, 0, 3, 0, "bp_load");
        tick();
        for (int k = 0; k < 4; k++) begin
            src_val[3] = 24'h200000 + 24'(k);
            req = 16'h0010; lock = '1; read_en = k[0];
            push(1'b0, 1'b0, 1'b1, 3, 24'hABCDEF, 0, $sformatf("bp_hold_%0d.rr", k));
            push(1'b1, 1'b0, 1'b1, 3, 24'hABCDEF, 0, $sformatf("bp_hold_%0d.fx", k));
            tick();
        end
        sink_ready = 1'b1; read_en = 1'b1; lock = '0; req = 16'h0008;
        src_val[3] = 24'h111111;
        exp_beat(3, 0, 3, 0, "bp_release");
        tick();

        do_reset("reset_burst");
        req = 16'h0006; lock = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            src_val[1] = 24'h310000 + 24'(k);
            exp_beat(1, k, 1, k, $sformatf("burst_%0d", k));
            tick();
        end
        src_val[1] = 24'h31AAAA;
        exp_beat(2, 0, 1, 0, "burst_cap");
        tick();
        src_val[1] = 24'h31BBBB;
        exp_beat(1, 0, 1, 1, "after_cap");
        tick();

        do_reset("reset_rden");
        req = 16'h0020; lock = 16'h0020;
        exp_beat(5, 0, 5, 0, "rden_grant");
        tick();
        held = src_val[5];
        read_en = 1'b0; src_val[5] = 24'h555555;
        exp_idle(held, held, "rden_drop");
        tick();
        exp_idle(held, held, "rden_still_low");
        tick();
        read_en = 1'b1;
        exp_beat(5, 0, 5, 0, "rden_restore");
        tick();

        lock = 16'h0020;
        do_reset("reset_mid_burst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
